// File: rtl/riscv_run_monitor_if.sv
// Control/status bundle between riscv_run_monitor (slave) and whoever drives
// the run and watches its outcome (master: a bench, a bring-up wrapper).
interface riscv_run_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             pc_valid_i;
  logic [XLEN-1:0]  pc_i;
  logic             core_rst_n_o;
  logic             running_o;
  logic             done_o;
  logic             pass_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic [CNT_W-1:0] retire_count_o;
  logic [XLEN-1:0]  halt_pc_o;

  modport master (
    output start_i, pc_valid_i, pc_i,
    input  core_rst_n_o, running_o, done_o, pass_o, timeout_o,
    input  cycle_count_o, retire_count_o, halt_pc_o
  );

  modport slave (
    input  start_i, pc_valid_i, pc_i,
    output core_rst_n_o, running_o, done_o, pass_o, timeout_o,
    output cycle_count_o, retire_count_o, halt_pc_o
  );
endinterface

// File: rtl/riscv_run_monitor.sv
// Run controller for riscv_processor: sequences the core reset, counts cycles and
// retirements, and ends the run on a PC self-loop halt or a cycle-limit timeout.
module riscv_run_monitor #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 2000,
  parameter int              STALL_LIMIT  = 4,
  parameter logic [XLEN-1:0] PASS_PC      = XLEN'(32'h0000_0100)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  riscv_run_monitor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_e;

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int MW = $clog2(STALL_LIMIT + 1);

  localparam logic [RW-1:0]    RstLoad   = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CycleLast = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [MW-1:0]    MatchHalt = MW'(STALL_LIMIT);

  state_e           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic             last_valid_q, last_valid_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic             begin_run;
  logic             pc_repeat;
  logic             halt;
  logic [MW-1:0]    match_inc;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    halt_pc_d    = halt_pc_q;
    match_cnt_d  = match_cnt_q;
    last_valid_d = last_valid_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    begin_run    = 1'b0;
    halt         = 1'b0;
    pc_repeat    = last_valid_q && (bus.pc_i == halt_pc_q);
    match_inc    = match_cnt_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          begin_run = 1'b1;
        end
      end
      RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      RUN: begin
        cycle_cnt_d = (cycle_cnt_q == CntMax) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        if (bus.pc_valid_i) begin
          retire_cnt_d = (retire_cnt_q == CntMax) ? retire_cnt_q : retire_cnt_q + 1'b1;
          halt_pc_d    = bus.pc_i;
          last_valid_d = 1'b1;
          match_cnt_d  = pc_repeat ? match_inc : '0;
          halt         = pc_repeat && (match_inc == MatchHalt);
        end
        // Halt outranks a timeout landing on the same cycle.
        if (halt) begin
          state_d   = DONE;
          pass_d    = (bus.pc_i == PASS_PC);
          timeout_d = 1'b0;
        end else if (cycle_cnt_q == CycleLast) begin
          state_d   = DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (begin_run) begin
      state_d      = RESET;
      rst_cnt_d    = RstLoad;
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
      halt_pc_d    = '0;
      match_cnt_d  = '0;
      last_valid_d = 1'b0;
      pass_d       = 1'b0;
      timeout_d    = 1'b0;
    end

    core_rst_n_d = (state_d == RUN) || (state_d == DONE);
    running_d    = (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      halt_pc_q    <= '0;
      match_cnt_q  <= '0;
      last_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      halt_pc_q    <= halt_pc_d;
      match_cnt_q  <= match_cnt_d;
      last_valid_q <= last_valid_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign bus.core_rst_n_o   = core_rst_n_q;
  assign bus.running_o      = running_q;
  assign bus.done_o         = done_q;
  assign bus.pass_o         = pass_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.cycle_count_o  = cycle_cnt_q;
  assign bus.retire_count_o = retire_cnt_q;
  assign bus.halt_pc_o      = halt_pc_q;

endmodule
